// File: rtl/fifo_rd_pkg.sv
// Shared constants and pointer helper for the FIFO stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int BUF_PTR_W = 2;

  typedef logic [BUF_PTR_W-1:0] buf_ptr_t;

  // Advance a circular-buffer pointer, wrapping after the last entry.
  function automatic buf_ptr_t next_ptr(input buf_ptr_t p);
    return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/stream_buf3.sv
// Three-entry skid buffer that turns registered FIFO read data into a valid/ready stream.
// Latency: a word pushed at edge N is visible on out_data/out_valid in the cycle after edge N.
// Backpressure: holds up to three words while pop_ready is low; the caller must never push into a full buffer.
module stream_buf3
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  pop,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  buf_ptr_t              wr_ptr;
  buf_ptr_t              rd_ptr;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & pop_ready;

  // Storage, pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The read-credit rule upstream must make an overflowing push impossible.
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == 2'd3)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a registered-output FIFO and presents its words as a valid/ready stream with a per-burst last flag.
// Latency: first word is valid two cycles after the read is issued; one word per cycle in steady state.
// Backpressure: m_ready low lets at most three words accumulate, then reads stop; m_ready never reaches fifo_rd_en.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4   // must be >= 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_data,
  output logic                           fifo_cs,
  output logic                           fifo_rd_en,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_last,
  output logic [$clog2(BURST_LEN+1)-1:0] beat_cnt
);

  localparam int                BCW       = $clog2(BURST_LEN + 1);
  localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BURST_LEN - 1);

  logic       inflight;
  logic       pop;
  logic [1:0] count;
  logic [2:0] credit_used;

  // Buffered words plus the word still in the FIFO's output register must leave room for one more.
  assign credit_used = {1'b0, count} + {2'b00, inflight};
  assign fifo_cs     = en;
  assign fifo_rd_en  = en & ~fifo_empty & ~rst & (credit_used < 3'(BUF_DEPTH));

  // A read issued this cycle produces fifo_data next cycle.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  // Beat index within the burst; wraps on the accepted last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  assign m_last = m_valid & (beat_cnt == LAST_BEAT);

  stream_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data),
    .pop_ready (m_ready),
    .out_valid (m_valid),
    .out_data  (m_data),
    .pop       (pop),
    .count     (count)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader with an upstream FIFO model and stream reference.
// Latency: n/a.
// Backpressure: m_ready driven per scenario, randomised in the gapped scenario.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [2:0]    beat_cnt;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .beat_cnt   (beat_cnt)
  );

  // Upstream FIFO contents and the reference view of the stream.
  logic [DW-1:0] fq[$];      // words still inside the upstream FIFO
  logic [DW-1:0] exp_q[$];   // words read out of the FIFO, not yet accepted downstream
  int  issued, landed, accepted;
  bit  inflight_m, rst_prev, force_empty;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic settle();
    fifo_empty = force_empty || (fq.size() == 0);
    #1;
  endtask

  // One clock cycle: check outputs against the reference, then advance FIFO and reference.
  task automatic tick();
    logic rd, hs, exp_vld, exp_rd;
    settle();
    exp_vld = (landed > accepted);
    exp_rd  = en && !fifo_empty && ((issued - accepted) < 3);
    n_cmp++;
    if (fifo_cs !== en) begin
      n_bad++; $display("FAIL fifo_cs: got %b want %b", fifo_cs, en);
    end
    if (rst) begin
      n_cmp++;
      if (fifo_rd_en !== 1'b0) begin
        n_bad++; $display("FAIL rd_en_in_reset: got %b want 0", fifo_rd_en);
      end
      if (rst_prev) begin
        n_cmp++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || beat_cnt !== 3'd0 || m_data !== '0) begin
          n_bad++;
          $display("FAIL reset_state: got vld=%b last=%b beat=%0d data=%h want 0/0/0/0",
                   m_valid, m_last, beat_cnt, m_data);
        end
      end
    end else begin
      n_cmp++;
      if (m_valid !== exp_vld) begin
        n_bad++; $display("FAIL m_valid: got %b want %b", m_valid, exp_vld);
      end
      n_cmp++;
      if (fifo_rd_en !== exp_rd) begin
        n_bad++; $display("FAIL fifo_rd_en: got %b want %b", fifo_rd_en, exp_rd);
      end
      n_cmp++;
      if (beat_cnt !== 3'(accepted % BL)) begin
        n_bad++; $display("FAIL beat_cnt: got %0d want %0d", beat_cnt, accepted % BL);
      end
      n_cmp++;
      if (m_last !== (exp_vld && (accepted % BL == BL - 1))) begin
        n_bad++; $display("FAIL m_last: got %b want %b", m_last, exp_vld && (accepted % BL == BL - 1));
      end
      if (exp_vld && exp_q.size() > 0) begin
        n_cmp++;
        if (m_data !== exp_q[0]) begin
          n_bad++; $display("FAIL m_data: got %h want %h", m_data, exp_q[0]);
        end
      end
    end
    rd = fifo_rd_en;
    hs = m_valid && m_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      issued = 0; landed = 0; accepted = 0; inflight_m = 1'b0;
      exp_q.delete();
      fifo_data = '0;
    end else begin
      if (inflight_m) landed++;
      if (hs) begin
        accepted++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      inflight_m = rd;
      if (rd) begin
        issued++;
        n_cmp++;
        if (fq.size() == 0) begin
          n_bad++; $display("FAIL fifo_underrun: got read with 0 words want no read");
        end else begin
          fifo_data = fq.pop_front();
          exp_q.push_back(fifo_data);
        end
      end
    end
    rst_prev = rst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) fq.push_back(32'h10 + i);
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    settle();
    n_cmp++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || beat_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got rd=%b vld=%b last=%b beat=%0d want 0/0/0/0",
               fifo_rd_en, m_valid, m_last, beat_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] want;
    rst = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      settle();
      want = 32'h10 + DW'(k) - 32'd2;
      n_cmp++;
      if (m_valid !== (k >= 2 && k <= 9)) begin
        n_bad++; $display("FAIL stream_valid@%0d: got %b want %b", k, m_valid, (k >= 2 && k <= 9));
      end
      if (k >= 2 && k <= 9) begin
        n_cmp++;
        if (m_data !== want || m_last !== (k == 5 || k == 9)) begin
          n_bad++;
          $display("FAIL stream_beat@%0d: got data=%h last=%b want data=%h last=%b",
                   k, m_data, m_last, want, (k == 5 || k == 9));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int pulses, a0, g;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(32'h10 + i);
    pulses = 0;
    a0 = accepted;
    repeat (6) begin
      settle();
      if (fifo_rd_en === 1'b1) pulses++;
      tick();
    end
    settle();
    n_cmp++;
    if (pulses != 3) begin
      n_bad++; $display("FAIL bp_rd_pulses: got %0d want 3", pulses);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 32'h10) begin
      n_bad++; $display("FAIL bp_hold: got vld=%b data=%h want 1/00000010", m_valid, m_data);
    end
    m_ready = 1'b1;
    g = 0;
    while ((fq.size() > 0 || landed > accepted || inflight_m) && g < 30) begin
      tick(); g++;
    end
    n_cmp++;
    if (accepted - a0 != 8) begin
      n_bad++; $display("FAIL bp_delivered: got %0d want 8", accepted - a0);
    end
  endtask

  task automatic test_gapped();
    int a0, g;
    for (int i = 0; i < 20; i++) fq.push_back($urandom);
    a0 = accepted;
    for (int c = 0; c < 60; c++) begin
      force_empty = c[0];
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    force_empty = 1'b0;
    m_ready = 1'b1;
    g = 0;
    while ((fq.size() > 0 || landed > accepted || inflight_m) && g < 50) begin
      tick(); g++;
    end
    n_cmp++;
    if (accepted - a0 != 20) begin
      n_bad++; $display("FAIL gapped_delivered: got %0d want 20", accepted - a0);
    end
  endtask

  task automatic test_enable();
    int a0, g;
    m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) fq.push_back(32'hA0 + i);
    a0 = accepted;
    repeat (3) tick();
    en = 1'b0;
    m_ready = 1'b1;
    repeat (6) tick();
    settle();
    n_cmp++;
    if (accepted - a0 != 3 || fq.size() != 2) begin
      n_bad++;
      $display("FAIL en_drain: got delivered=%0d left=%0d want 3/2", accepted - a0, fq.size());
    end
    n_cmp++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || fifo_cs !== 1'b0) begin
      n_bad++;
      $display("FAIL en_idle: got vld=%b rd=%b cs=%b want 0/0/0", m_valid, fifo_rd_en, fifo_cs);
    end
    en = 1'b1;
    g = 0;
    while ((fq.size() > 0 || landed > accepted || inflight_m) && g < 20) begin
      tick(); g++;
    end
  endtask

  task automatic test_mid_reset();
    int g, beats;
    fq.delete();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back(32'hC0 + i);
    m_ready = 1'b1;
    g = 0;
    while (accepted < 1 && g < 10) begin tick(); g++; end
    m_ready = 1'b0;
    g = 0;
    while ((landed - accepted) < 2 && g < 10) begin tick(); g++; end
    settle();
    n_cmp++;
    if (m_valid !== 1'b1 || beat_cnt !== 3'd1) begin
      n_bad++; $display("FAIL mr_pre: got vld=%b beat=%0d want 1/1", m_valid, beat_cnt);
    end
    fq.delete();
    rst = 1'b1; tick(); rst = 1'b0;
    settle();
    n_cmp++;
    if (m_valid !== 1'b0 || beat_cnt !== 3'd0) begin
      n_bad++; $display("FAIL mr_post: got vld=%b beat=%0d want 0/0", m_valid, beat_cnt);
    end
    for (int i = 0; i < 8; i++) fq.push_back(32'hE0 + i);
    m_ready = 1'b1;
    beats = 0;
    g = 0;
    while (beats < 4 && g < 20) begin
      settle();
      if (m_valid === 1'b1 && m_ready) begin
        beats++;
        n_cmp++;
        if (m_last !== (beats == 4)) begin
          n_bad++; $display("FAIL mr_burst_beat%0d: got last=%b want %b", beats, m_last, beats == 4);
        end
      end
      tick(); g++;
    end
    n_cmp++;
    if (beats != 4) begin
      n_bad++; $display("FAIL mr_timeout: got %0d beats want 4", beats);
    end
    g = 0;
    while ((fq.size() > 0 || landed > accepted || inflight_m) && g < 20) begin
      tick(); g++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; m_ready = 1'b0; fifo_data = '0; fifo_empty = 1'b1;
    force_empty = 1'b0; rst_prev = 1'b0;
    issued = 0; landed = 0; accepted = 0; inflight_m = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_gapped();
    test_enable();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
